elevator_request_queue: RTL and testbench

Per-floor request register feeding the elevator direction resolver. Synchronizes raw floor-button levels and turns each press (rising edge) into a latched pending request. Clears a floor's request when the door controller reports arrival at that floor. Presents the pending set as `queue_status`, plus `queue_empty` and a pending count, for direction resolution.

---
 rtl/elevator_request_queue.sv | 68 ++++++
 tb/tb_elevator_request_queue.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/elevator_request_queue.sv
// Per-floor request register: synchronized button presses latch pending requests, arrivals clear them.
// Press visible 2 cycles after first sample, clear and ack 1 cycle; never stalls, back-to-back arrivals accepted.
module elevator_request_queue #(
  parameter int NUM_FLOORS = 7,
  parameter int FLOOR_W    = 3,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] floor_btn,
  input  logic                  arrive_valid,
  input  logic [FLOOR_W-1:0]    arrive_floor,
  output logic                  arrive_ack,
  output logic                  arrive_err,
  output logic [NUM_FLOORS-1:0] queue_status,
  output logic                  queue_empty,
  output logic [CNT_W-1:0]      pending_count
);

  localparam logic [FLOOR_W:0] NUM_FLOORS_W = (FLOOR_W+1)'(NUM_FLOORS);

  logic [NUM_FLOORS-1:0] btn_s1;
  logic [NUM_FLOORS-1:0] btn_s2;
  logic [NUM_FLOORS-1:0] btn_d;
  logic [NUM_FLOORS-1:0] press;
  logic [NUM_FLOORS-1:0] clr;
  logic                  floor_oor;

  assign press     = btn_s2 & ~btn_d;
  assign floor_oor = ({1'b0, arrive_floor} >= NUM_FLOORS_W);

  // An out-of-range floor matches no bit, so nothing is cleared.
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      clr[i] = arrive_valid && (arrive_floor == FLOOR_W'(i));
    end
  end

  // Btn_d resets low so a button held through reset counts as one fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1       <= '0;
      btn_s2       <= '0;
      btn_d        <= '0;
      queue_status <= '0;
      arrive_ack   <= 1'b0;
      arrive_err   <= 1'b0;
    end else begin
      btn_s1       <= floor_btn;
      btn_s2       <= btn_s1;
      btn_d        <= btn_s2;
      queue_status <= (queue_status | press) & ~clr;
      arrive_ack   <= arrive_valid;
      arrive_err   <= arrive_valid & floor_oor;
    end
  end

  assign queue_empty = ~|queue_status;

  always_comb begin
    pending_count = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      pending_count = pending_count + CNT_W'(queue_status[i]);
    end
  end

endmodule

// File: tb/tb_elevator_request_queue.sv
// Directed bench for elevator_request_queue: hand-computed expectations checked with immediate assertions.
module tb_elevator_request_queue;

  logic       clk;
  logic       rst_n;
  logic [6:0] floor_btn;
  logic       arrive_valid;
  logic [2:0] arrive_floor;
  logic       arrive_ack;
  logic       arrive_err;
  logic [6:0] queue_status;
  logic       queue_empty;
  logic [2:0] pending_count;

  int passed;
  int total;

  elevator_request_queue #(.NUM_FLOORS(7), .FLOOR_W(3), .CNT_W(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .floor_btn     (floor_btn),
    .arrive_valid  (arrive_valid),
    .arrive_floor  (arrive_floor),
    .arrive_ack    (arrive_ack),
    .arrive_err    (arrive_err),
    .queue_status  (queue_status),
    .queue_empty   (queue_empty),
    .pending_count (pending_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_out(input string tag, input logic [6:0] st, input logic [2:0] cnt,
                         input logic ack, input logic err);
    chk({tag, ".status"}, 32'(queue_status), 32'(st));
    chk({tag, ".count"},  32'(pending_count), 32'(cnt));
    chk({tag, ".empty"},  32'(queue_empty), 32'(st == 7'd0));
    chk({tag, ".ack"},    32'(arrive_ack), 32'(ack));
    chk({tag, ".err"},    32'(arrive_err), 32'(err));
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    rst_n        = 1'b0;
    floor_btn    = 7'd0;
    arrive_valid = 1'b0;
    arrive_floor = 3'd0;

    // Reset state
    #12;
    chk_out("reset", 7'd0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);

    // Single press on floor 1, visible two edges after first sample
    floor_btn = 7'b0000010;
    tick(1);
    chk_out("press1.k", 7'd0, 3'd0, 1'b0, 1'b0);
    tick(1);
    chk_out("press1.k1", 7'd0, 3'd0, 1'b0, 1'b0);
    tick(1);
    chk_out("press1.k2", 7'b0000010, 3'd1, 1'b0, 1'b0);
    tick(3);
    chk_out("press1.held", 7'b0000010, 3'd1, 1'b0, 1'b0);

    // Add floor 6, then clear it
    floor_btn = 7'b1000010;
    tick(2);
    chk("press6.early", 32'(queue_status), 32'(7'b0000010));
    tick(1);
    chk_out("press6", 7'b1000010, 3'd2, 1'b0, 1'b0);
    arrive_valid = 1'b1;
    arrive_floor = 3'd6;
    tick(1);
    arrive_valid = 1'b0;
    chk_out("clear6", 7'b0000010, 3'd1, 1'b1, 1'b0);
    tick(1);
    chk_out("clear6.after", 7'b0000010, 3'd1, 1'b0, 1'b0);

    // Race: press on floor 3 meets clear of floor 3; floor 5 press latches
    floor_btn = 7'b1101010;
    tick(2);
    arrive_valid = 1'b1;
    arrive_floor = 3'd3;
    tick(1);
    arrive_valid = 1'b0;
    chk_out("race", 7'b0100010, 3'd2, 1'b1, 1'b0);
    tick(2);
    chk_out("race.after", 7'b0100010, 3'd2, 1'b0, 1'b0);

    // Build status 0101000: clear floor 1, release and re-press floor 3
    arrive_valid = 1'b1;
    arrive_floor = 3'd1;
    floor_btn    = 7'b1100010;
    tick(1);
    arrive_valid = 1'b0;
    chk_out("clear1", 7'b0100000, 3'd1, 1'b1, 1'b0);
    tick(3);
    floor_btn = 7'b1101010;
    tick(3);
    chk_out("repress3", 7'b0101000, 3'd2, 1'b0, 1'b0);

    // Out-of-range arrival
    arrive_valid = 1'b1;
    arrive_floor = 3'd7;
    tick(1);
    arrive_valid = 1'b0;
    arrive_floor = 3'd0;
    chk_out("oor", 7'b0101000, 3'd2, 1'b1, 1'b1);
    tick(1);
    chk_out("oor.after", 7'b0101000, 3'd2, 1'b0, 1'b0);

    // Held floor 0: cleared while held stays clear until release and re-press
    floor_btn = 7'b1101011;
    tick(3);
    chk_out("hold0.set", 7'b0101001, 3'd3, 1'b0, 1'b0);
    arrive_valid = 1'b1;
    arrive_floor = 3'd0;
    tick(1);
    arrive_valid = 1'b0;
    chk_out("hold0.clr", 7'b0101000, 3'd2, 1'b1, 1'b0);
    tick(5);
    chk_out("hold0.held", 7'b0101000, 3'd2, 1'b0, 1'b0);
    floor_btn = 7'b1101010;
    tick(3);
    floor_btn = 7'b1101011;
    tick(2);
    chk("repress0.k1", 32'(queue_status), 32'(7'b0101000));
    tick(1);
    chk_out("repress0.k2", 7'b0101001, 3'd3, 1'b0, 1'b0);

    // All floors pending
    floor_btn = 7'd0;
    tick(3);
    floor_btn = 7'h7F;
    tick(3);
    chk_out("full", 7'h7F, 3'd7, 1'b0, 1'b0);

    // Async reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 7'd0, 3'd0, 1'b0, 1'b0);
    tick(2);
    chk_out("in_rst", 7'd0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    chk("rel.e2", 32'(queue_status), 32'(7'd0));
    tick(1);
    chk_out("rel.e3", 7'h7F, 3'd7, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
